// File: rtl/controlador_de_memoria_pkg.sv
// controlador_de_memoria_pkg: op encodings, FSM states and address stride shared by the memory controller
package pacote_controlador_memoria;
  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_STORE = 2'b01, OP_COPY = 2'b10, OP_RSVD = 2'b11} op_t;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_STORE, ST_CPY_RD, ST_CPY_WR, ST_RESP} state_t;
  localparam int ADDR_INC = 2;
endpackage

// File: rtl/controlador_de_memoria_if.sv
// controlador_de_memoria_if: request/response handshake bundle for the memory controller
interface controlador_de_memoria_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_addr2;
  logic [DATA_W-1:0] req_wdata;
  logic [LEN_W-1:0]  req_len;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  modport slave (
    input  req_valid, req_op, req_addr, req_addr2, req_wdata, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport master (
    output req_valid, req_op, req_addr, req_addr2, req_wdata, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/controlador_de_memoria_gerador_de_enderecos.sv
// gerador_de_enderecos: source/destination/count registers, loaded on accept and stepped after each copy write
module gerador_de_enderecos
  import pacote_controlador_memoria::*;
#(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] src,
  output logic [ADDR_W-1:0] dst,
  output logic [LEN_W-1:0]  count
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src   <= '0;
      dst   <= '0;
      count <= '0;
    end else if (load) begin
      src   <= addr;
      dst   <= addr2;
      count <= len;
    end else if (step) begin
      src   <= src + ADDR_W'(ADDR_INC);
      dst   <= dst + ADDR_W'(ADDR_INC);
      count <= count - LEN_W'(1);
    end
  end
endmodule

// File: rtl/controlador_de_memoria.sv
// controlador_de_memoria: LOAD/STORE/COPY memory controller FSM.
// Define ALIGN_CHECK_EN to reject odd byte addresses with rsp_err instead of forwarding them.
module controlador_de_memoria
  import pacote_controlador_memoria::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  controlador_de_memoria_if.slave     bus,
  output logic [ADDR_W-1:0]           mem_access_addr,
  output logic [DATA_W-1:0]           mem_write_data,
  output logic                        mem_write_en,
  output logic                        mem_read,
  input  logic [DATA_W-1:0]           mem_read_data
);
  state_t            state, nxt;
  op_t               op;
  logic [DATA_W-1:0] wdata_q, buf_q, rdata_q;
  logic              err_q;
  logic [ADDR_W-1:0] src, dst;
  logic [LEN_W-1:0]  count;
  logic              accept, rsvd, len_zero, mis;
  assign op       = op_t'(bus.req_op);
  assign accept   = bus.req_valid && state == ST_IDLE;
  assign rsvd     = op == OP_RSVD;
  assign len_zero = bus.req_len == '0;
`ifdef ALIGN_CHECK_EN
  assign mis = ((op == OP_LOAD || op == OP_STORE) && bus.req_addr[0]) ||
               (op == OP_COPY && !len_zero && (bus.req_addr[0] || bus.req_addr2[0]));
`else
  assign mis = 1'b0;
`endif
  gerador_de_enderecos #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_gen (
    .clk, .rst_n, .load(accept), .step(state == ST_CPY_WR),
    .addr(bus.req_addr), .addr2(bus.req_addr2), .len(bus.req_len),
    .src, .dst, .count
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      wdata_q <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
        err_q   <= rsvd || mis;
      end
      if (state == ST_LOAD) rdata_q <= mem_read_data;
      if (state == ST_CPY_RD) buf_q <= mem_read_data;
    end
  end
  always_comb begin
    nxt             = state;
    mem_read        = 1'b0;
    mem_write_en    = 1'b0;
    mem_access_addr = '0;
    mem_write_data  = '0;
    case (state)
      ST_IDLE:   if (bus.req_valid) nxt = (rsvd || mis || (op == OP_COPY && len_zero)) ? ST_RESP :
                                          op == OP_LOAD ? ST_LOAD : op == OP_STORE ? ST_STORE : ST_CPY_RD;
      ST_LOAD:   begin
        nxt             = ST_RESP;
        mem_read        = 1'b1;
        mem_access_addr = src;
      end
      ST_STORE:  begin
        nxt             = ST_RESP;
        mem_write_en    = 1'b1;
        mem_access_addr = src;
        mem_write_data  = wdata_q;
      end
      ST_CPY_RD: begin
        nxt             = ST_CPY_WR;
        mem_read        = 1'b1;
        mem_access_addr = src;
      end
      ST_CPY_WR: begin
        nxt             = count == LEN_W'(1) ? ST_RESP : ST_CPY_RD;
        mem_write_en    = 1'b1;
        mem_access_addr = dst;
        mem_write_data  = buf_q;
      end
      ST_RESP:   if (bus.rsp_ready) nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
    // reset must kill any in-flight strobe in the same cycle it is asserted
    mem_read     = mem_read && rst_n;
    mem_write_en = mem_write_en && rst_n;
  end
  assign bus.req_ready = state == ST_IDLE;
  assign bus.rsp_valid = state == ST_RESP;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_controlador_de_memoria.sv
// tb_controlador_de_memoria: randomized transactions against a word-array reference model of the memory controller
module tb_controlador_de_memoria;
  localparam int AW = 16, DW = 16, LW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  controlador_de_memoria_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus();
  logic [AW-1:0] mem_access_addr;
  logic [DW-1:0] mem_write_data, mem_read_data;
  logic          mem_write_en, mem_read;
  controlador_de_memoria #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );
  logic [DW-1:0] mem [2**(AW-1)];
  logic [DW-1:0] ref_mem [2**(AW-1)];
  int n_chk = 0, n_err = 0, n_rd = 0, n_wr = 0, n_both = 0, n_rsp = 0;
  logic [AW-1:0] rd_q[$];
  assign mem_read_data = mem_read ? mem[mem_access_addr[AW-1:1]] : '0;
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_access_addr[AW-1:1]] = mem_write_data;
    if (mem_read) begin
      n_rd++;
      rd_q.push_back(mem_access_addr);
    end
    if (mem_write_en) n_wr++;
    if (mem_read && mem_write_en) n_both++;
    if (bus.rsp_valid && bus.rsp_ready) n_rsp++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic poke(input logic [15:0] a, input logic [15:0] v);
    mem[a[15:1]] = v;
    ref_mem[a[15:1]] = v;
  endtask
  function automatic logic [15:0] peek(input logic [15:0] a);
    return mem[a[15:1]];
  endfunction
  task automatic cmp_mem(input string tag);
    int m = 0;
    for (int i = 0; i < 2**(AW-1); i++) if (mem[i] !== ref_mem[i]) m++;
    chk(tag, m, 0);
  endtask
  // full transaction: model predicts response, latency (edges counted from the accepting edge) and memory traffic
  task automatic run(input logic [1:0] op, input logic [15:0] a, input logic [15:0] a2,
                     input logic [15:0] w, input logic [7:0] len, input int hold);
    logic exp_err, mis;
    logic [15:0] exp_rd, s, d;
    int exp_lat, exp_nrd, exp_nwr, t;
    mis = 1'b0;
`ifdef ALIGN_CHECK_EN
    mis = ((op == 2'd0 || op == 2'd1) && a[0]) || (op == 2'd2 && len != 0 && (a[0] || a2[0]));
`endif
    exp_err = op == 2'd3 || mis;
    exp_rd = '0;
    exp_lat = 1;
    exp_nrd = 0;
    exp_nwr = 0;
    if (!exp_err) begin
      if (op == 2'd0) begin
        exp_rd = ref_mem[a[15:1]];
        exp_lat = 2;
        exp_nrd = 1;
      end else if (op == 2'd1) begin
        ref_mem[a[15:1]] = w;
        exp_lat = 2;
        exp_nwr = 1;
      end else begin
        for (int i = 0; i < int'(len); i++) begin
          s = a + 16'(2 * i);
          d = a2 + 16'(2 * i);
          ref_mem[d[15:1]] = ref_mem[s[15:1]];
        end
        exp_lat = 1 + 2 * int'(len);
        exp_nrd = int'(len);
        exp_nwr = int'(len);
      end
    end
    @(negedge clk);
    bus.req_op = op;
    bus.req_addr = a;
    bus.req_addr2 = a2;
    bus.req_wdata = w;
    bus.req_len = len;
    bus.req_valid = 1'b1;
    t = 0;
    while (!bus.req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready", bus.req_ready, 1);
    n_rd = 0;
    n_wr = 0;
    n_both = 0;
    rd_q.delete();
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    t = 1;
    while (!bus.rsp_valid && t < 600) begin
      @(negedge clk);
      t++;
    end
    chk("latency", t, exp_lat);
    chk("rsp_err", bus.rsp_err, exp_err);
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", bus.rsp_valid, 1);
      chk("hold_rdata", bus.rsp_rdata, exp_rd);
      chk("hold_err", bus.rsp_err, exp_err);
      chk("hold_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    chk("n_rd", n_rd, exp_nrd);
    chk("n_wr", n_wr, exp_nwr);
    chk("rd_wr_overlap", n_both, 0);
    chk("back_idle", bus.req_ready, 1);
  endtask
  initial begin
    int r0;
    logic [15:0] a, a2;
    for (int i = 0; i < 2**(AW-1); i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    bus.req_valid = 1'b0;
    bus.req_op = '0;
    bus.req_addr = '0;
    bus.req_addr2 = '0;
    bus.req_wdata = '0;
    bus.req_len = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_we", mem_write_en, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    chk("rst_err", bus.rsp_err, 0);
    rst_n = 1'b1;
    run(2'd1, 16'h0010, 16'h0, 16'hBEEF, 8'd0, 0);
    run(2'd0, 16'h0010, 16'h0, 16'h0, 8'd0, 0);
    chk("load_beef", peek(16'h0010), 16'hBEEF);
    poke(16'h0020, 16'h1111);
    poke(16'h0022, 16'h2222);
    poke(16'h0024, 16'h3333);
    r0 = n_rsp;
    run(2'd2, 16'h0020, 16'h0040, 16'h0, 8'd3, 0);
    chk("cpy_one_rsp", n_rsp - r0, 1);
    chk("cpy_w0", peek(16'h0040), 16'h1111);
    chk("cpy_w1", peek(16'h0042), 16'h2222);
    chk("cpy_w2", peek(16'h0044), 16'h3333);
    run(2'd2, 16'hFFFE, 16'h0100, 16'h0, 8'd2, 0);
    chk("wrap_nrd", rd_q.size(), 2);
    chk("wrap_rd0", rd_q[0], 16'hFFFE);
    chk("wrap_rd1", rd_q[1], 16'h0000);
    run(2'd0, 16'h0011, 16'h0, 16'h0, 8'd0, 0);
    run(2'd0, 16'h0010, 16'h0, 16'h0, 8'd0, 5);
    run(2'd3, 16'h0010, 16'h0, 16'h0, 8'd0, 0);
    run(2'd2, 16'h0030, 16'h0050, 16'h0, 8'd0, 0);
    cmp_mem("mem_directed");
    for (int i = 0; i < 4; i++) begin
      poke(16'h0200 + 16'(2 * i), 16'hA000 + 16'(i));
      poke(16'h0300 + 16'(2 * i), 16'h5000 + 16'(i));
    end
    @(negedge clk);
    bus.req_op = 2'd2;
    bus.req_addr = 16'h0200;
    bus.req_addr2 = 16'h0300;
    bus.req_len = 8'd4;
    bus.req_valid = 1'b1;
    n_wr = 0;
    r0 = n_rsp;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_pre_we", mem_write_en, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_we_kill", mem_write_en, 0);
    chk("rst_rd_kill", mem_read, 0);
    @(posedge clk);
    #1;
    chk("rst_idle", bus.req_ready, 1);
    chk("rst_no_valid", bus.rsp_valid, 0);
    chk("rst_n_wr", n_wr, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_no_rsp", n_rsp - r0, 0);
    ref_mem[16'h0300 >> 1] = ref_mem[16'h0200 >> 1];
    cmp_mem("mem_after_rst");
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      a2 = 16'($urandom);
      if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
      if ($urandom_range(0, 3) != 0) a2[0] = 1'b0;
      run(2'($urandom_range(0, 3)), a, a2, 16'($urandom), 8'($urandom_range(0, 6)), $urandom_range(0, 2));
    end
    cmp_mem("mem_final");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/controlador_de_memoria.md
CONTROLADOR_DE_MEMORIA -- requirements
Module: controlador_de_memoria

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 16, word width.
REQ-003 SHALL have parameter LEN_W, default 8, copy word-count width.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports req_valid in 1 / req_ready out 1, request handshake.
REQ-007 SHALL have port req_op  in  2  operation: 00 LOAD, 01 STORE, 10 COPY, 11 reserved.
REQ-008 SHALL have ports req_addr in ADDR_W, byte address (LOAD/STORE target, COPY source); req_addr2 in ADDR_W, COPY destination.
REQ-009 SHALL have ports req_wdata in DATA_W, STORE data; req_len in LEN_W, COPY word count.
REQ-010 SHALL have ports rsp_valid out 1 / rsp_ready in 1, response handshake.
REQ-011 SHALL have ports rsp_rdata out DATA_W, LOAD data (0 otherwise); rsp_err out 1, error flag.
REQ-012 SHALL have memory-side ports mem_access_addr out ADDR_W, mem_write_data out DATA_W, mem_write_en out 1, mem_read out 1, mem_read_data in DATA_W; the memory writes on the clk edge while mem_write_en=1 and returns read data combinationally while mem_read=1.

Function
REQ-013 SHALL implement states IDLE, LOAD, STORE, CPY_RD, CPY_WR, RESP; req_ready=1 only in IDLE.
REQ-014 SHALL accept a request on an edge with req_valid=1 and req_ready=1, registering op, addresses, wdata and len.
REQ-015 SHALL, on accept: LOAD→LOAD, STORE→STORE, COPY with len>0→CPY_RD, COPY with len=0→RESP (err=0), op 11→RESP (err=1), with no memory access for the last two.
REQ-016 SHALL, in LOAD, drive mem_read=1 and mem_access_addr=addr for exactly one cycle, capture mem_read_data into rsp_rdata at that cycle's end, then go to RESP; rsp_valid rises 2 cycles after the accepting edge.
REQ-017 SHALL, in STORE, drive mem_write_en=1, mem_access_addr=addr, mem_write_data=wdata for exactly one cycle, then go to RESP with rsp_rdata=0.
REQ-018 SHALL, in COPY, alternate CPY_RD (mem_read=1 at src, capture word into internal buffer) and CPY_WR (mem_write_en=1 at dst with buffered word); after each CPY_WR, src+=2, dst+=2, count-=1; go to RESP when count reaches 0; total 2*len memory cycles.
REQ-019 SHALL wrap src/dst modulo 2^ADDR_W (0xFFFE+2 = 0x0000) without error.
REQ-020 SHALL hold rsp_valid=1 with stable rsp_rdata/rsp_err in RESP until an edge with rsp_ready=1, then return to IDLE; no new request is accepted before that edge.
REQ-021 SHALL drive mem_read=0, mem_write_en=0, mem_access_addr=0, mem_write_data=0 in IDLE and RESP; mem_read and mem_write_en are never 1 simultaneously.
REQ-022 SHALL leave the LEN_W-wide count unsigned; len=2^LEN_W-1 is the maximum transfer.

Reset
REQ-023 SHALL, on an edge with rst_n=0, enter IDLE, clear rsp_valid, rsp_rdata, rsp_err, buffer, count and registered addresses.
REQ-024 SHALL force mem_read=0 and mem_write_en=0 combinationally while rst_n=0, so reset mid-STORE or mid-COPY performs no further write; a partially completed COPY is abandoned with no response.

Configuration
REQ-025 SHALL, with ALIGN_CHECK_EN defined, flag any accepted LOAD/STORE with addr[0]=1, or COPY (len>0) with src[0]=1 or dst[0]=1, by going directly to RESP with rsp_err=1, rsp_rdata=0 and no memory access.
REQ-026 SHALL, without ALIGN_CHECK_EN, forward addresses unchanged regardless of bit 0 and never set rsp_err except for op 11.

Structure
REQ-027 SHALL take op encodings, the state enumeration and the address increment constant (2) from shared package pacote_controlador_memoria.
REQ-028 SHALL place src/dst/count registers and increment logic in one sub-module, gerador_de_enderecos; the FSM stays in the top.

Verification
REQ-029 SHALL cover: STORE addr=0x0010 wdata=0xBEEF, then LOAD 0x0010 -> rsp_rdata=0xBEEF, err=0, rsp_valid 2 cycles after accept.
REQ-030 SHALL cover: COPY src=0x0020 dst=0x0040 len=3 over preset 0x1111/0x2222/0x3333 -> 0x0040..0x0044 match, exactly 6 memory cycles, one response.
REQ-031 SHALL cover: COPY src=0xFFFE dst=0x0100 len=2 -> reads 0xFFFE then 0x0000, no error.
REQ-032 SHALL cover: LOAD addr=0x0011 -> err=1 and no mem_read with ALIGN_CHECK_EN; data of 0x0010, err=0 without.
REQ-033 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0; op=11 -> err=1 with no memory access.
REQ-034 SHALL cover: rst_n low during CPY_WR of COPY len=4 -> no write that cycle, IDLE next, no response, remaining destinations unchanged.
